// File: rtl/polymul_bram_host.sv
// Operand/result bank host for the polynomial multiplier: loads A/B banks from a
// 64-bit stream, sequences core reset/run, and unloads bank A. Optional RUN watchdog: POLYMUL_HOST_TIMEOUT_EN.
module polymul_bram_host #(
  parameter int ADDR_W     = 10,
  parameter int RST_CYCLES = 2
`ifdef POLYMUL_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [1:0]          cmd_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         out_data,
  output logic                busy,
  output logic                err,
  output logic                core_rst,
  output logic [1:0]          core_mode,
  input  logic [ADDR_W-1:0]   core_read_address,
  input  logic                core_read_poly_op_sel,
  output logic [127:0]        core_data128_in,
  input  logic [ADDR_W-1:0]   core_write_address,
  input  logic                core_wea,
  input  logic [127:0]        core_data128_out,
  input  logic                core_done
);

  localparam int N   = 1 << ADDR_W;
  localparam int BW  = ADDR_W + 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = {BW{1'b1}};
`ifdef POLYMUL_HOST_TIMEOUT_EN
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN_RST, S_RUN, S_UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic            sel_q, sel_d;
  logic            err_q, err_d;
  logic [1:0]      mode_q, mode_d;
  logic            out_valid_q, out_valid_d;
`ifdef POLYMUL_HOST_TIMEOUT_EN
  logic [WDW-1:0]  wdog_q, wdog_d;
`endif

  logic [63:0]     low_q;
  logic            low_en;
  logic            wr_a, wr_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]    wr_data;
  logic [127:0]    bank_a [N];
  logic [127:0]    bank_b [N];
  logic [127:0]    core_rd_q, unl_rd_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    rcnt_d      = rcnt_q;
    sel_d       = sel_q;
    err_d       = err_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    low_en      = 1'b0;
    wr_a        = 1'b0;
    wr_b        = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
`ifdef POLYMUL_HOST_TIMEOUT_EN
    wdog_d      = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          beat_d = '0;
          rcnt_d = '0;
          case (cmd_op)
            2'b00, 2'b01: begin
              state_d = S_LOAD;
              sel_d   = cmd_op[0];
            end
            2'b10: begin
              if (cmd_mode == 2'b11) begin
                err_d = 1'b1;
              end else begin
                mode_d  = cmd_mode;
                state_d = S_RUN_RST;
              end
            end
            default: begin
              state_d     = S_UNLOAD;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          // Even beats park the low half; odd beats commit the whole word.
          low_en = ~beat_q[0];
          if (beat_q[0]) begin
            wr_a    = ~sel_q;
            wr_b    = sel_q;
            wr_addr = beat_q[BW-1:1];
            wr_data = {in_data, low_q};
          end
          if (beat_q == BEAT_LAST) state_d = S_IDLE;
          beat_d = beat_q + 1'b1;
        end
      end
      S_RUN_RST: begin
        if (rcnt_q == RCW'(RST_CYCLES - 1)) state_d = S_RUN;
        else rcnt_d = rcnt_q + 1'b1;
      end
      S_RUN: begin
        if (core_wea) begin
          wr_a    = 1'b1;
          wr_addr = core_write_address;
          wr_data = core_data128_out;
        end
        if (core_done) state_d = S_IDLE;
`ifdef POLYMUL_HOST_TIMEOUT_EN
        if (!core_done) begin
          if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
`endif
      end
      S_UNLOAD: begin
        if (out_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      rcnt_q      <= '0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
`ifdef POLYMUL_HOST_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rcnt_q      <= rcnt_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
`ifdef POLYMUL_HOST_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  // Bank storage and low-half staging carry no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_a) bank_a[wr_addr] <= wr_data;
    if (wr_b) bank_b[wr_addr] <= wr_data;
    if (low_en) low_q <= in_data;
  end

  // Both read ports are read-first; the unload port re-reads the word of the next beat every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rd_q <= '0;
      unl_rd_q  <= '0;
    end else begin
      core_rd_q <= core_read_poly_op_sel ? bank_b[core_read_address] : bank_a[core_read_address];
      unl_rd_q  <= bank_a[beat_d[BW-1:1]];
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign in_ready        = (state_q == S_LOAD);
  assign out_valid       = out_valid_q;
  assign out_data        = beat_q[0] ? unl_rd_q[127:64] : unl_rd_q[63:0];
  assign err             = err_q;
  assign core_rst        = (state_q != S_RUN);
  assign core_mode       = mode_q;
  assign core_data128_in = core_rd_q;

endmodule

// File: tb/tb_polymul_bram_host.sv
// Bench for polymul_bram_host with N = 4 and the bench acting as a stub core.
module tb_polymul_bram_host;
  localparam int ADDR_W = 2;
  localparam int N      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op, cmd_mode;
  logic              in_valid, in_ready;
  logic [63:0]       in_data;
  logic              out_valid, out_ready;
  logic [63:0]       out_data;
  logic              busy, err, core_rst;
  logic [1:0]        core_mode;
  logic [ADDR_W-1:0] core_read_address, core_write_address;
  logic              core_read_poly_op_sel, core_wea, core_done;
  logic [127:0]      core_data128_in, core_data128_out;

  int checks = 0;
  int errors = 0;
  logic [127:0] ref_a [N];
  logic [127:0] ref_b [N];
  logic [63:0]  stim [2*N];

  polymul_bram_host #(
    .ADDR_W(ADDR_W), .RST_CYCLES(2)
`ifdef POLYMUL_HOST_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .core_rst(core_rst), .core_mode(core_mode),
    .core_read_address(core_read_address), .core_read_poly_op_sel(core_read_poly_op_sel),
    .core_data128_in(core_data128_in),
    .core_write_address(core_write_address), .core_wea(core_wea),
    .core_data128_out(core_data128_out), .core_done(core_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] mode);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait got %0b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mode  = mode;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed_beats(input int nbeats);
    int k, guard;
    k = 0;
    guard = 0;
    while (k < nbeats && guard < 200) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = stim[k];
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != nbeats) begin
      errors++;
      $display("FAIL load_beats_accepted got %0d want %0d", k, nbeats);
    end
  endtask

  task automatic core_read(input logic sel, input logic [ADDR_W-1:0] addr, output logic [127:0] data);
    core_read_poly_op_sel = sel;
    core_read_address     = addr;
    tick();
    data = core_data128_in;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, in_ready, out_valid, busy, err, core_rst, core_mode} !== 8'b1000_0100) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 10000100",
               {cmd_ready, in_ready, out_valid, busy, err, core_rst, core_mode});
    end
    checks++;
    if (out_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_out_data got %h want 0", out_data);
    end
    checks++;
    if (core_data128_in !== 128'h0) begin
      errors++;
      $display("FAIL reset_core_rd got %h want 0", core_data128_in);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_read();
    logic [127:0] d;
    for (int i = 0; i < 2*N; i++) stim[i] = 64'(i + 1);
    send_cmd(2'b00, 2'b00);
    feed_beats(2*N);
    for (int k = 0; k < N; k++) ref_a[k] = {stim[2*k+1], stim[2*k]};
    core_read(1'b0, 2'd0, d);
    checks++;
    if (d !== {64'h2, 64'h1}) begin
      errors++;
      $display("FAIL load_a_word0 got %h want %h", d, {64'h2, 64'h1});
    end
    core_read(1'b0, 2'd3, d);
    checks++;
    if (d !== {64'h8, 64'h7}) begin
      errors++;
      $display("FAIL load_a_word3 got %h want %h", d, {64'h8, 64'h7});
    end
    for (int i = 0; i < 2*N; i++) stim[i] = {$urandom, $urandom};
    send_cmd(2'b01, 2'b00);
    feed_beats(2*N);
    for (int k = 0; k < N; k++) ref_b[k] = {stim[2*k+1], stim[2*k]};
    for (int k = 0; k < N; k++) begin
      core_read(1'b1, k[ADDR_W-1:0], d);
      checks++;
      if (d !== ref_b[k]) begin
        errors++;
        $display("FAIL load_b_word%0d got %h want %h", k, d, ref_b[k]);
      end
      core_read(1'b0, k[ADDR_W-1:0], d);
      checks++;
      if (d !== ref_a[k]) begin
        errors++;
        $display("FAIL bank_a_kept_word%0d got %h want %h", k, d, ref_a[k]);
      end
    end
  endtask

  task automatic test_run_handshake();
    logic [127:0] d, wdata;
    logic [1:0] m;
    logic [ADDR_W-1:0] wa;
    send_cmd(2'b10, 2'b10);
    checks++;
    if ({busy, core_rst, core_mode} !== 4'b1110) begin
      errors++;
      $display("FAIL run_t1 busy/rst/mode got %b want 1110", {busy, core_rst, core_mode});
    end
    tick();
    checks++;
    if (core_rst !== 1'b1) begin
      errors++;
      $display("FAIL run_rst_t2 got %0b want 1", core_rst);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0) begin
      errors++;
      $display("FAIL run_rst_t3 got %0b want 0", core_rst);
    end
    wdata = {2{64'hAAAA_AAAA_AAAA_AAAA}};
    core_wea = 1'b1;
    core_write_address = 2'd1;
    core_data128_out = wdata;
    tick();
    core_wea = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, core_rst} !== 2'b10) begin
      errors++;
      $display("FAIL run_wait busy/rst got %b want 10", {busy, core_rst});
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if ({cmd_ready, busy, core_rst} !== 3'b101) begin
      errors++;
      $display("FAIL run_done ready/busy/rst got %b want 101", {cmd_ready, busy, core_rst});
    end
    ref_a[1] = wdata;
    core_read(1'b0, 2'd1, d);
    checks++;
    if (d !== ref_a[1]) begin
      errors++;
      $display("FAIL run_result_word1 got %h want %h", d, ref_a[1]);
    end
    // second run, random legal mode, with a stray done pulse before release
    m = 2'($urandom_range(0, 2));
    send_cmd(2'b10, m);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if ({busy, core_rst} !== 2'b11) begin
      errors++;
      $display("FAIL early_done_ignored busy/rst got %b want 11", {busy, core_rst});
    end
    tick();
    checks++;
    if ({core_rst, core_mode} !== {1'b0, m}) begin
      errors++;
      $display("FAIL run2_release rst/mode got %b want %b", {core_rst, core_mode}, {1'b0, m});
    end
    wa = ADDR_W'($urandom_range(0, N-1));
    wdata = {$urandom, $urandom, $urandom, $urandom};
    core_wea = 1'b1;
    core_write_address = wa;
    core_data128_out = wdata;
    core_done = 1'b1;
    tick();
    core_wea = 1'b0;
    core_done = 1'b0;
    ref_a[wa] = wdata;
    for (int k = 0; k < N; k++) begin
      core_read(1'b0, k[ADDR_W-1:0], d);
      checks++;
      if (d !== ref_a[k]) begin
        errors++;
        $display("FAIL run2_word%0d got %h want %h", k, d, ref_a[k]);
      end
    end
  endtask

  task automatic test_unload(input logic full_rate);
    int got, cyc, first_seen, last_hs;
    logic [63:0] exp_beat;
    logic [3:0] pat;
    pat = 4'b1001;
    got = 0;
    cyc = 0;
    first_seen = -1;
    last_hs = -1;
    send_cmd(2'b11, 2'b00);
    while (got < 2*N && cyc < 200) begin
      if (full_rate) out_ready = 1'b1;
      else out_ready = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
      if (out_valid) begin
        if (first_seen < 0) first_seen = cyc;
        exp_beat = ref_a[got/2][64*(got%2) +: 64];
        checks++;
        if (out_data !== exp_beat) begin
          errors++;
          $display("FAIL unload_beat%0d got %h want %h", got, out_data, exp_beat);
        end
        if (out_ready) begin
          got++;
          last_hs = cyc;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (got != 2*N) begin
      errors++;
      $display("FAIL unload_count got %0d want %0d", got, 2*N);
    end
    checks++;
    if (first_seen < 0 || first_seen > 2) begin
      errors++;
      $display("FAIL unload_first_valid got cycle %0d want <= 2", first_seen);
    end
    if (full_rate) begin
      checks++;
      if (last_hs - first_seen != 2*N - 1) begin
        errors++;
        $display("FAIL unload_rate got span %0d want %0d", last_hs - first_seen, 2*N - 1);
      end
    end
    repeat (2) begin
      checks++;
      if ({out_valid, cmd_ready} !== 2'b01) begin
        errors++;
        $display("FAIL unload_end valid/ready got %b want 01", {out_valid, cmd_ready});
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_collision();
    logic [127:0] old_w, new_w;
    send_cmd(2'b10, 2'b00);
    tick();
    tick();
    checks++;
    if (core_rst !== 1'b0) begin
      errors++;
      $display("FAIL coll_release got %0b want 0", core_rst);
    end
    old_w = ref_a[2];
    new_w = {$urandom, $urandom, $urandom, $urandom};
    core_wea = 1'b1;
    core_write_address = 2'd2;
    core_data128_out = new_w;
    core_read_poly_op_sel = 1'b0;
    core_read_address = 2'd2;
    tick();
    core_wea = 1'b0;
    checks++;
    if (core_data128_in !== old_w) begin
      errors++;
      $display("FAIL coll_read_first got %h want %h", core_data128_in, old_w);
    end
    tick();
    checks++;
    if (core_data128_in !== new_w) begin
      errors++;
      $display("FAIL coll_read_next got %h want %h", core_data128_in, new_w);
    end
    ref_a[2] = new_w;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [127:0] d;
    for (int i = 0; i < 3; i++) stim[i] = {$urandom, $urandom};
    send_cmd(2'b01, 2'b00);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = stim[i];
      tick();
    end
    in_valid = 1'b0;
    ref_b[0] = {stim[1], stim[0]};
    pulse_rst();
    checks++;
    if ({in_ready, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midload_rst in_ready/busy/ready got %b want 001", {in_ready, busy, cmd_ready});
    end
    core_read(1'b1, 2'd0, d);
    checks++;
    if (d !== ref_b[0]) begin
      errors++;
      $display("FAIL midload_word0_kept got %h want %h", d, ref_b[0]);
    end
    for (int i = 0; i < 2*N; i++) stim[i] = {$urandom, $urandom};
    send_cmd(2'b01, 2'b00);
    feed_beats(2*N);
    for (int k = 0; k < N; k++) ref_b[k] = {stim[2*k+1], stim[2*k]};
    for (int k = 0; k < N; k++) begin
      core_read(1'b1, k[ADDR_W-1:0], d);
      checks++;
      if (d !== ref_b[k]) begin
        errors++;
        $display("FAIL reload_b_word%0d got %h want %h", k, d, ref_b[k]);
      end
    end
  endtask

  task automatic test_illegal_mode();
    send_cmd(2'b10, 2'b11);
    repeat (2) begin
      checks++;
      if ({err, core_rst, cmd_ready, busy} !== 4'b1110) begin
        errors++;
        $display("FAIL illegal_mode err/rst/ready/busy got %b want 1110", {err, core_rst, cmd_ready, busy});
      end
      tick();
    end
    pulse_rst();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_by_rst got %0b want 0", err);
    end
  endtask

`ifdef POLYMUL_HOST_TIMEOUT_EN
  task automatic test_watchdog();
    send_cmd(2'b10, 2'b00);
    tick();
    tick();
    repeat (63) tick();
    checks++;
    if ({busy, err, core_rst} !== 3'b100) begin
      errors++;
      $display("FAIL wdog_before busy/err/rst got %b want 100", {busy, err, core_rst});
    end
    tick();
    tick();
    checks++;
    if ({err, core_rst, cmd_ready} !== 3'b111) begin
      errors++;
      $display("FAIL wdog_fire err/rst/ready got %b want 111", {err, core_rst, cmd_ready});
    end
    pulse_rst();
  endtask
`else
  task automatic test_no_timeout();
    send_cmd(2'b10, 2'b01);
    tick();
    tick();
    repeat (100) tick();
    checks++;
    if ({busy, core_rst, err} !== 3'b100) begin
      errors++;
      $display("FAIL run_no_timeout busy/rst/err got %b want 100", {busy, core_rst, err});
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++;
    if ({cmd_ready, core_rst} !== 2'b11) begin
      errors++;
      $display("FAIL run_no_timeout_done ready/rst got %b want 11", {cmd_ready, core_rst});
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mode = 2'b00;
    in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0;
    core_read_address = '0; core_read_poly_op_sel = 1'b0;
    core_write_address = '0; core_wea = 1'b0; core_data128_out = '0;
    core_done = 1'b0;
    test_reset();
    test_load_read();
    test_run_handshake();
    test_unload(1'b0);
    test_unload(1'b1);
    test_collision();
    test_unload(1'b0);
    test_reset_mid_load();
    test_illegal_mode();
`ifdef POLYMUL_HOST_TIMEOUT_EN
    test_watchdog();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
